// File: rtl/sprite_rom_arbiter_if.sv
// Client-side bus of sprite_rom_arbiter: per-requester request/address,
// one-hot grant, and the shared registered read return.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       rd_data;
  logic [N_REQ-1:0]        rd_valid;
  logic                    busy;

  modport master (output req, addr, input gnt, rd_data, rd_valid, busy);
  modport slave  (input req, addr, output gnt, rd_data, rd_valid, busy);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one async-read sprite ROM between N_REQ clients.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 2496
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sprite_rom_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [DATA_W-1:0]    rom_data
);
  localparam int                PTR_W   = $clog2(N_REQ);
  localparam logic [PTR_W:0]    N_REQ_P = (PTR_W+1)'(N_REQ);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  rd_valid_q;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] rd_data_q;
  logic              oob_q;

  // A requester granted this cycle still shows its old address; skip it.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    logic [PTR_W:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= N_REQ_P) idx = idx - N_REQ_P;
      if (!win_found && elig[idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
  end

  assign win_addr   = bus.addr[win_idx*ADDR_W +: ADDR_W];
  assign win_onehot = N_REQ'(1) << win_idx;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge Clk) begin
    if (Reset)
      rr_ptr <= '0;
    else if (win_found)
      rr_ptr <= (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt_q      <= '0;
      rom_addr   <= '0;
      oob_q      <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= gnt_q;
      // Out-of-range reads return transparent index 0.
      rd_data_q  <= oob_q ? '0 : rom_data;
      if (win_found) begin
        gnt_q <= win_onehot;
        if (win_addr < DEPTH_A) begin
          rom_addr <= win_addr;
          oob_q    <= 1'b0;
        end else begin
          rom_addr <= '0;
          oob_q    <= 1'b1;
        end
      end else begin
        gnt_q <= '0;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (|gnt_q) | (|rd_valid_q);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 2496;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] mem [DEPTH];

  sprite_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 Clk = ~Clk;

  assign rom_data = (rom_addr < ADDR_W'(DEPTH)) ? mem[rom_addr[11:0]] : '0;

  int total = 0;
  int bad   = 0;

  logic [N_REQ-1:0] drv_req = '0;
  int               drv_addr [N_REQ];

  // reference model state
  int m_gnt = 0, m_rdv = 0, m_rdd = 0, m_rom = 0, m_oob = 0, m_rr = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         a0, a1, a2, a3;
    logic [3:0] g;
    logic [3:0] v;
    int         src;   // -2: no data check, -1: expect 0, else expect mem[src]
    int         ra;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input int a0, input int a1,
                     input int a2, input int a3, input logic [3:0] g, input logic [3:0] v,
                     input int src, input int ra);
    vec_t e;
    e.rst = rst; e.req = req; e.a0 = a0; e.a1 = a1; e.a2 = a2; e.a3 = a3;
    e.g = g; e.v = v; e.src = src; e.ra = ra;
    tbl.push_back(e);
  endtask

  // Next-cycle outputs computed directly from the arbitration rules.
  task automatic model_edge();
    int w, ptr;
    if (Reset) begin
      m_gnt = 0; m_rdv = 0; m_rdd = 0; m_rom = 0; m_oob = 0; m_rr = 0;
      return;
    end
    m_rdv = m_gnt;
    m_rdd = m_oob ? 0 : int'(mem[m_rom]);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    ptr = 0;
`else
    ptr = m_rr;
`endif
    w = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (ptr + k) % N_REQ;
      if (w < 0 && drv_req[i] && ((m_gnt >> i) & 1) == 0) w = i;
    end
    if (w >= 0) begin
      m_gnt = 1 << w;
      if (drv_addr[w] < DEPTH) begin m_rom = drv_addr[w]; m_oob = 0; end
      else begin m_rom = 0; m_oob = 1; end
      m_rr = (w + 1) % N_REQ;
    end else begin
      m_gnt = 0;
    end
  endtask

  task automatic cycle();
    bus.req = drv_req;
    for (int i = 0; i < N_REQ; i++) bus.addr[i*ADDR_W +: ADDR_W] = ADDR_W'(drv_addr[i]);
    @(posedge Clk);
    model_edge();
    #1;
    check("model_gnt", 32'(bus.gnt), 32'(m_gnt));
    check("model_rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    if (m_rdv != 0) check("model_rd_data", 32'(bus.rd_data), 32'(m_rdd));
    check("model_rom_addr", 32'(rom_addr), 32'(m_rom));
    check("model_busy", 32'(bus.busy), 32'((m_gnt | m_rdv) != 0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'((i * 5 + (i >> 4) + 1) % 8);
    for (int i = 0; i < N_REQ; i++) drv_addr[i] = 0;
    bus.req  = '0;
    bus.addr = '0;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    add(1, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -1, 0);
    add(0, 4'b0110, 100, 200, 300, 400, 4'b0010, 4'b0000, -2, 200);
    add(0, 4'b0110, 100, 200, 300, 400, 4'b0100, 4'b0010, 200, 300);
    add(0, 4'b0110, 100, 200, 300, 400, 4'b0010, 4'b0100, 300, 200);
    add(0, 4'b1110, 100, 200, 300, 400, 4'b0100, 4'b0010, 200, 300);
    add(0, 4'b1110, 100, 200, 300, 400, 4'b0010, 4'b0100, 300, 200);
    add(0, 4'b1010, 100, 200, 300, 400, 4'b1000, 4'b0010, 200, 400);
    add(0, 4'b1010, 100, 200, 300, 400, 4'b0010, 4'b1000, 400, 200);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0010, 200, 200);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -2, 200);
`else
    add(1, 4'b0000,  10, 200, 300, 400, 4'b0000, 4'b0000, -1, 0);
    add(1, 4'b0000,  10, 200, 300, 400, 4'b0000, 4'b0000, -1, 0);
    add(0, 4'b0001,  10, 200, 300, 400, 4'b0001, 4'b0000, -2, 10);
    add(0, 4'b0001,  10, 200, 300, 400, 4'b0000, 4'b0001, 10, 10);
    add(0, 4'b0001,  10, 200, 300, 400, 4'b0001, 4'b0000, -2, 10);
    add(0, 4'b0000,  10, 200, 300, 400, 4'b0000, 4'b0001, 10, 10);
    add(0, 4'b0000,  10, 200, 300, 400, 4'b0000, 4'b0000, -2, 10);
    add(1, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -1, 0);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0001, 4'b0000, -2, 100);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0010, 4'b0001, 100, 200);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0100, 4'b0010, 200, 300);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b1000, 4'b0100, 300, 400);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0001, 4'b1000, 400, 100);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0001, 100, 100);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -2, 100);
    add(0, 4'b0010, 100, 2495, 300, 400, 4'b0010, 4'b0000, -2, 2495);
    add(0, 4'b0010, 100, 2496, 300, 400, 4'b0000, 4'b0010, 2495, 2495);
    add(0, 4'b0010, 100, 2496, 300, 400, 4'b0010, 4'b0000, -2, 0);
    add(0, 4'b0000, 100, 2496, 300, 400, 4'b0000, 4'b0010, -1, 0);
    add(0, 4'b0000, 100, 2496, 300, 400, 4'b0000, 4'b0000, -2, 0);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0100, 4'b0000, -2, 300);
    add(1, 4'b1111, 100, 200, 300, 400, 4'b0000, 4'b0000, -1, 0);
    add(0, 4'b1111, 100, 200, 300, 400, 4'b0001, 4'b0000, -2, 100);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0001, 100, 100);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -2, 100);
    add(0, 4'b0110, 100, 200, 300, 400, 4'b0010, 4'b0000, -2, 200);
    add(0, 4'b0010, 100, 200, 300, 400, 4'b0000, 4'b0010, 200, 200);
    add(0, 4'b0000, 100, 200, 300, 400, 4'b0000, 4'b0000, -2, 200);
`endif

    foreach (tbl[n]) begin
      Reset       = tbl[n].rst;
      drv_req     = tbl[n].req;
      drv_addr[0] = tbl[n].a0;
      drv_addr[1] = tbl[n].a1;
      drv_addr[2] = tbl[n].a2;
      drv_addr[3] = tbl[n].a3;
      cycle();
      check($sformatf("vec%0d_gnt", n), 32'(bus.gnt), 32'(tbl[n].g));
      check($sformatf("vec%0d_rd_valid", n), 32'(bus.rd_valid), 32'(tbl[n].v));
      check($sformatf("vec%0d_rom_addr", n), 32'(rom_addr), 32'(tbl[n].ra));
      check($sformatf("vec%0d_busy", n), 32'(bus.busy), 32'((tbl[n].g | tbl[n].v) != 0));
      if (tbl[n].src == -1)
        check($sformatf("vec%0d_rd_data", n), 32'(bus.rd_data), 32'(0));
      else if (tbl[n].src >= 0)
        check($sformatf("vec%0d_rd_data", n), 32'(bus.rd_data), 32'(mem[tbl[n].src]));
    end

    for (int c = 0; c < 2000; c++) begin
      Reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0) drv_req = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       drv_addr[i] = int'($urandom_range(DEPTH - 2, DEPTH + 1));
            1:       drv_addr[i] = int'($urandom_range(0, (1 << ADDR_W) - 1));
            default: drv_addr[i] = int'($urandom_range(0, DEPTH - 1));
          endcase
        end
      end
      cycle();
    end

    Reset   = 1'b0;
    drv_req = '0;
    cycle();
    cycle();
    check("drain_busy", 32'(bus.busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
